// File: rtl/mmu_tlb_unit_pkg.sv
// Shared field widths and TLB entry layout for the MMU translation cache.
package mmu_tlb_unit_pkg;

  localparam int TAG_W   = 16;
  localparam int TID_W   = 14;
  localparam int FLAG_W  = 14;
  localparam int PHYS_W  = 18;
  localparam int INDEX_W = 2;
  localparam int WAYS    = 4;
  localparam int SETS    = 1 << INDEX_W;
  localparam int WAY_W   = 2;
  localparam int ADDR_W  = TAG_W + INDEX_W;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [TID_W-1:0]  tid;
    logic [FLAG_W-1:0] flags;
    logic [PHYS_W-1:0] phys;
    logic              use_bit;
  } tlb_entry_t;

endpackage

// File: rtl/mmu_tlb_unit_if.sv
// Request/response bundle between the MMU request stage and the TLB unit.
interface mmu_tlb_unit_if;
  import mmu_tlb_unit_pkg::*;

  logic              iRD_REQ;
  logic [ADDR_W-1:0] iRD_ADDR;
  logic [TID_W-1:0]  iRD_TID;
  logic              oRD_VALID;
  logic              oRD_HIT;
  logic [FLAG_W-1:0] oRD_FLAGS;
  logic [PHYS_W-1:0] oRD_PHYS_ADDR;

  logic              iWR_REQ;
  logic [ADDR_W-1:0] iWR_ADDR;
  logic [TID_W-1:0]  iWR_TID;
  logic [FLAG_W-1:0] iWR_FLAGS;
  logic [PHYS_W-1:0] iWR_PHYS_ADDR;

  logic              iMB_WR_REQ;
  logic              iMB_WR_TYPE;
  logic              oMB_WR_FULL;
  logic              iMB_RD_REQ;
  logic              oMB_RD_VALID;
  logic              oMB_RD_TYPE;
  logic              oMB_RD_EMPTY;

  modport master (
    output iRD_REQ, iRD_ADDR, iRD_TID,
    input  oRD_VALID, oRD_HIT, oRD_FLAGS, oRD_PHYS_ADDR,
    output iWR_REQ, iWR_ADDR, iWR_TID, iWR_FLAGS, iWR_PHYS_ADDR,
    output iMB_WR_REQ, iMB_WR_TYPE, iMB_RD_REQ,
    input  oMB_WR_FULL, oMB_RD_VALID, oMB_RD_TYPE, oMB_RD_EMPTY
  );

  modport slave (
    input  iRD_REQ, iRD_ADDR, iRD_TID,
    output oRD_VALID, oRD_HIT, oRD_FLAGS, oRD_PHYS_ADDR,
    input  iWR_REQ, iWR_ADDR, iWR_TID, iWR_FLAGS, iWR_PHYS_ADDR,
    input  iMB_WR_REQ, iMB_WR_TYPE, iMB_RD_REQ,
    output oMB_WR_FULL, oMB_RD_VALID, oMB_RD_TYPE, oMB_RD_EMPTY
  );

endinterface

// File: rtl/mmu_tlb_unit_arbiter_matching_bridge.sv
// Matching bridge: FIFO of 1-bit miss types, pairing each miss with its later refill.
module arbiter_matching_bridge #(
  parameter int unsigned MB_DEPTH   = 16,
  parameter int unsigned MB_DEPTH_N = 4
) (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic iFLASH,
  input  logic iWR_REQ,
  input  logic iWR_TYPE,
  output logic oWR_FULL,
  input  logic iRD_REQ,
  output logic oRD_VALID,
  output logic oRD_TYPE,
  output logic oRD_EMPTY
);

  logic [MB_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MB_DEPTH_N:0]   cnt_q, cnt_d;
  logic [MB_DEPTH-1:0]   mem_q, mem_d;
  logic                  push, pop;

  assign oWR_FULL  = (cnt_q == (MB_DEPTH_N+1)'(MB_DEPTH));
  assign oRD_EMPTY = (cnt_q == '0);
  assign oRD_VALID = iRD_REQ && !oRD_EMPTY;
  assign oRD_TYPE  = mem_q[rd_ptr_q];

  // A pop on empty stays ignored even when a push lands in the same cycle.
  assign push = iWR_REQ && !oWR_FULL;
  assign pop  = iRD_REQ && !oRD_EMPTY;

  // Next-state for pointers, count and storage; flush empties and drops any push.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (iFLASH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = iWR_TYPE;
        wr_ptr_d        = wr_ptr_q + MB_DEPTH_N'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + MB_DEPTH_N'(1);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + (MB_DEPTH_N+1)'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - (MB_DEPTH_N+1)'(1);
      end
    end
  end

  // FIFO state register.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/mmu_tlb_unit.sv
// 4-set x 4-way TLB with use-bit aging, plus the miss/refill matching bridge.
module mmu_tlb_unit
  import mmu_tlb_unit_pkg::*;
#(
  parameter int unsigned LRU_N      = 10,
  parameter int unsigned MB_DEPTH   = 16,
  parameter int unsigned MB_DEPTH_N = 4
) (
  input  logic          iCLOCK,
  input  logic          inRESET,
  input  logic          iFLASH,
  mmu_tlb_unit_if.slave bus
);

  tlb_entry_t tlb_q [SETS][WAYS];
  tlb_entry_t tlb_d [SETS][WAYS];

  logic [INDEX_W-1:0] rd_set, wr_set;
  logic [TAG_W-1:0]   rd_tag, wr_tag;
  logic [WAYS-1:0]    rd_hit_vec, wr_match_vec;
  logic               rd_hit;
  logic [WAY_W-1:0]   hit_way, wr_way;
  tlb_entry_t         hit_entry;
  logic               wr_found;

  logic [31:0]        lru_cnt_q, lru_cnt_d;
  logic               lru_wrap;

  logic               rd_valid_q, rd_hit_q;
  logic [FLAG_W-1:0]  rd_flags_q;
  logic [PHYS_W-1:0]  rd_phys_q;

  assign rd_set = bus.iRD_ADDR[INDEX_W-1:0];
  assign rd_tag = bus.iRD_ADDR[ADDR_W-1:INDEX_W];
  assign wr_set = bus.iWR_ADDR[INDEX_W-1:0];
  assign wr_tag = bus.iWR_ADDR[ADDR_W-1:INDEX_W];

  // Per-way tag+tid compare for the lookup and fill ports.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      rd_hit_vec[w]   = tlb_q[rd_set][w].valid && (tlb_q[rd_set][w].tag == rd_tag) &&
                        (tlb_q[rd_set][w].tid == bus.iRD_TID);
      wr_match_vec[w] = tlb_q[wr_set][w].valid && (tlb_q[wr_set][w].tag == wr_tag) &&
                        (tlb_q[wr_set][w].tid == bus.iWR_TID);
    end
  end

  // Select the (unique) hitting way; a lookup during flush always misses.
  always_comb begin
    hit_way   = '0;
    hit_entry = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (rd_hit_vec[w]) begin
        hit_way   = WAY_W'(w);
        hit_entry = tlb_q[rd_set][w];
      end
    end
  end
  assign rd_hit = (|rd_hit_vec) && !iFLASH;

  // Fill victim: matching way, else first invalid, else first unused, else way 0.
  always_comb begin
    wr_way   = '0;
    wr_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!wr_found && wr_match_vec[w]) begin
        wr_way   = WAY_W'(w);
        wr_found = 1'b1;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!wr_found && !tlb_q[wr_set][w].valid) begin
        wr_way   = WAY_W'(w);
        wr_found = 1'b1;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!wr_found && !tlb_q[wr_set][w].use_bit) begin
        wr_way   = WAY_W'(w);
        wr_found = 1'b1;
      end
    end
  end

  assign lru_wrap  = (lru_cnt_q == LRU_N - 1);
  assign lru_cnt_d = lru_wrap ? '0 : lru_cnt_q + 32'd1;

  // Array next-state: aging, then hit marking, then fill; flush overrides all.
  always_comb begin
    tlb_d = tlb_q;
    if (lru_wrap) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tlb_d[s][w].use_bit = 1'b0;
        end
      end
    end
    if (bus.iRD_REQ && rd_hit) begin
      tlb_d[rd_set][hit_way].use_bit = 1'b1;
    end
    if (bus.iWR_REQ) begin
      tlb_d[wr_set][wr_way] = '{valid: 1'b1, tag: wr_tag, tid: bus.iWR_TID,
                                flags: bus.iWR_FLAGS, phys: bus.iWR_PHYS_ADDR, use_bit: 1'b1};
    end
    if (iFLASH) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tlb_d[s][w].valid   = 1'b0;
          tlb_d[s][w].use_bit = 1'b0;
        end
      end
    end
  end

  // TLB array and aging counter registers.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      tlb_q     <= '{default: '0};
      lru_cnt_q <= '0;
    end else begin
      tlb_q     <= tlb_d;
      lru_cnt_q <= lru_cnt_d;
    end
  end

  // Registered lookup result; data fields only move on a hit.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_flags_q <= '0;
      rd_phys_q  <= '0;
    end else begin
      rd_valid_q <= bus.iRD_REQ;
      if (bus.iRD_REQ) begin
        rd_hit_q <= rd_hit;
        if (rd_hit) begin
          rd_flags_q <= hit_entry.flags;
          rd_phys_q  <= hit_entry.phys;
        end
      end
    end
  end

  assign bus.oRD_VALID     = rd_valid_q;
  assign bus.oRD_HIT       = rd_hit_q;
  assign bus.oRD_FLAGS     = rd_flags_q;
  assign bus.oRD_PHYS_ADDR = rd_phys_q;

  arbiter_matching_bridge #(
    .MB_DEPTH   (MB_DEPTH),
    .MB_DEPTH_N (MB_DEPTH_N)
  ) u_bridge (
    .iCLOCK    (iCLOCK),
    .inRESET   (inRESET),
    .iFLASH    (iFLASH),
    .iWR_REQ   (bus.iMB_WR_REQ),
    .iWR_TYPE  (bus.iMB_WR_TYPE),
    .oWR_FULL  (bus.oMB_WR_FULL),
    .iRD_REQ   (bus.iMB_RD_REQ),
    .oRD_VALID (bus.oMB_RD_VALID),
    .oRD_TYPE  (bus.oMB_RD_TYPE),
    .oRD_EMPTY (bus.oMB_RD_EMPTY)
  );

endmodule

// File: tb/tb_mmu_tlb_unit.sv
// Directed bench for mmu_tlb_unit: lookup/fill, replacement, flush, bridge FIFO.
module tb_mmu_tlb_unit;

  logic clk;
  logic rst_n;
  logic flash;
  int   n_checks;
  int   n_errors;

  mmu_tlb_unit_if bus ();

  mmu_tlb_unit #(
    .LRU_N      (1000),
    .MB_DEPTH   (16),
    .MB_DEPTH_N (4)
  ) dut (
    .iCLOCK  (clk),
    .inRESET (rst_n),
    .iFLASH  (flash),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [17:0] addr, input logic [13:0] tid);
    bus.iRD_REQ  = 1'b1;
    bus.iRD_ADDR = addr;
    bus.iRD_TID  = tid;
    step();
    bus.iRD_REQ  = 1'b0;
  endtask

  task automatic fill(input logic [17:0] addr, input logic [13:0] tid,
                      input logic [17:0] phys, input logic [13:0] flags);
    bus.iWR_REQ       = 1'b1;
    bus.iWR_ADDR      = addr;
    bus.iWR_TID       = tid;
    bus.iWR_PHYS_ADDR = phys;
    bus.iWR_FLAGS     = flags;
    step();
    bus.iWR_REQ       = 1'b0;
  endtask

  task automatic push(input logic t);
    bus.iMB_WR_REQ  = 1'b1;
    bus.iMB_WR_TYPE = t;
    step();
    bus.iMB_WR_REQ  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    flash = 1'b0;
    bus.iRD_REQ = 1'b0; bus.iRD_ADDR = '0; bus.iRD_TID = '0;
    bus.iWR_REQ = 1'b0; bus.iWR_ADDR = '0; bus.iWR_TID = '0;
    bus.iWR_FLAGS = '0; bus.iWR_PHYS_ADDR = '0;
    bus.iMB_WR_REQ = 1'b0; bus.iMB_WR_TYPE = 1'b0; bus.iMB_RD_REQ = 1'b0;
    #12;
    check("rst_rd_valid", bus.oRD_VALID, 0);
    check("rst_rd_hit", bus.oRD_HIT, 0);
    check("rst_rd_flags", bus.oRD_FLAGS, 0);
    check("rst_rd_phys", bus.oRD_PHYS_ADDR, 0);
    check("rst_mb_full", bus.oMB_WR_FULL, 0);
    check("rst_mb_valid", bus.oMB_RD_VALID, 0);
    check("rst_mb_type", bus.oMB_RD_TYPE, 0);
    check("rst_mb_empty", bus.oMB_RD_EMPTY, 1);
    rst_n = 1'b1;
    step();

    // Cold lookup misses.
    lookup(18'h00005, 14'd3);
    check("cold_valid", bus.oRD_VALID, 1);
    check("cold_hit", bus.oRD_HIT, 0);

    // Fill then hit; wrong tid misses; idle cycle holds data.
    fill(18'h00005, 14'd3, 18'h2ABCD, 14'h0015);
    lookup(18'h00005, 14'd3);
    check("fill_hit", bus.oRD_HIT, 1);
    check("fill_phys", bus.oRD_PHYS_ADDR, 32'h2ABCD);
    check("fill_flags", bus.oRD_FLAGS, 32'h0015);
    lookup(18'h00005, 14'd4);
    check("tid_valid", bus.oRD_VALID, 1);
    check("tid_hit", bus.oRD_HIT, 0);
    step();
    check("idle_valid", bus.oRD_VALID, 0);
    check("idle_phys_hold", bus.oRD_PHYS_ADDR, 32'h2ABCD);

    // Lookup in the same cycle as a fill sees old contents.
    bus.iRD_REQ = 1'b1; bus.iRD_ADDR = 18'h00009; bus.iRD_TID = 14'd1;
    fill(18'h00009, 14'd1, 18'h00111, 14'h0001);
    bus.iRD_REQ = 1'b0;
    check("samecyc_hit", bus.oRD_HIT, 0);
    lookup(18'h00009, 14'd1);
    check("nextcyc_hit", bus.oRD_HIT, 1);
    check("nextcyc_phys", bus.oRD_PHYS_ADDR, 32'h00111);

    // Replacement in set 2: tags 0x100..0x104.
    for (int i = 0; i < 4; i++) begin
      fill({16'h0100 + 16'(i), 2'b10}, 14'd7, 18'h01000 + 18'(i), 14'h0002);
    end
    for (int i = 1; i < 4; i++) begin
      lookup({16'h0100 + 16'(i), 2'b10}, 14'd7);
      check("set2_prehit", bus.oRD_HIT, 1);
    end
    fill(18'h00412, 14'd7, 18'h01004, 14'h0002);
    lookup(18'h00402, 14'd7);
    check("victim_miss", bus.oRD_HIT, 0);
    lookup(18'h00412, 14'd7);
    check("fifth_hit", bus.oRD_HIT, 1);
    check("fifth_phys", bus.oRD_PHYS_ADDR, 32'h01004);
    lookup(18'h00406, 14'd7);
    check("way1_kept", bus.oRD_PHYS_ADDR, 32'h01001);

    // Refill of a matching entry overwrites it in place.
    fill(18'h00406, 14'd7, 18'h02222, 14'h0003);
    lookup(18'h00406, 14'd7);
    check("over_phys", bus.oRD_PHYS_ADDR, 32'h02222);
    check("over_flags", bus.oRD_FLAGS, 32'h0003);
    lookup(18'h0040A, 14'd7);
    check("over_neighbour", bus.oRD_HIT, 1);

    // Flush with bridge holding 3 and a same-cycle lookup.
    push(1'b1); push(1'b0); push(1'b1);
    check("pre_flush_empty", bus.oMB_RD_EMPTY, 0);
    flash = 1'b1;
    lookup(18'h00005, 14'd3);
    flash = 1'b0;
    check("flush_lookup_hit", bus.oRD_HIT, 0);
    check("flush_empty", bus.oMB_RD_EMPTY, 1);
    lookup(18'h00005, 14'd3);
    check("post_flush_hit", bus.oRD_HIT, 0);

    // Fill bridge to 16, drop a 17th, drain in order.
    for (int i = 0; i < 16; i++) push(i[0]);
    check("full", bus.oMB_WR_FULL, 1);
    push(1'b1);
    check("full_after_drop", bus.oMB_WR_FULL, 1);
    for (int i = 0; i < 16; i++) begin
      bus.iMB_RD_REQ = 1'b1;
      #1;
      check("pop_valid", bus.oMB_RD_VALID, 1);
      check("pop_type", bus.oMB_RD_TYPE, 32'(i % 2));
      step();
    end
    bus.iMB_RD_REQ = 1'b0;
    check("drained_empty", bus.oMB_RD_EMPTY, 1);
    check("drained_full", bus.oMB_WR_FULL, 0);
    bus.iMB_RD_REQ = 1'b1;
    #1;
    check("empty_pop_valid", bus.oMB_RD_VALID, 0);
    step();
    bus.iMB_RD_REQ = 1'b0;

    // Push+pop with count 1: count holds, head advances.
    push(1'b1);
    bus.iMB_WR_REQ = 1'b1; bus.iMB_WR_TYPE = 1'b0; bus.iMB_RD_REQ = 1'b1;
    #1;
    check("pp_valid", bus.oMB_RD_VALID, 1);
    check("pp_type", bus.oMB_RD_TYPE, 1);
    step();
    bus.iMB_WR_REQ = 1'b0; bus.iMB_RD_REQ = 1'b0;
    check("pp_not_empty", bus.oMB_RD_EMPTY, 0);
    check("pp_head", bus.oMB_RD_TYPE, 0);
    bus.iMB_RD_REQ = 1'b1;
    step();
    bus.iMB_RD_REQ = 1'b0;
    check("pp_count1_empty", bus.oMB_RD_EMPTY, 1);

    // Push+pop on empty: pop ignored, push lands.
    bus.iMB_WR_REQ = 1'b1; bus.iMB_WR_TYPE = 1'b1; bus.iMB_RD_REQ = 1'b1;
    #1;
    check("ep_valid", bus.oMB_RD_VALID, 0);
    step();
    bus.iMB_WR_REQ = 1'b0; bus.iMB_RD_REQ = 1'b0;
    check("ep_not_empty", bus.oMB_RD_EMPTY, 0);
    check("ep_type", bus.oMB_RD_TYPE, 1);

    // Reset mid-operation discards TLB and bridge.
    fill(18'h00005, 14'd3, 18'h2ABCD, 14'h0015);
    lookup(18'h00005, 14'd3);
    check("pre_rst_hit", bus.oRD_HIT, 1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_hit", bus.oRD_HIT, 0);
    check("mid_rst_phys", bus.oRD_PHYS_ADDR, 0);
    check("mid_rst_empty", bus.oMB_RD_EMPTY, 1);
    rst_n = 1'b1;
    step();
    lookup(18'h00005, 14'd3);
    check("post_rst_valid", bus.oRD_VALID, 1);
    check("post_rst_hit", bus.oRD_HIT, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
